rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter sharing one resource between 4 requesters.
- Uses rotating-priority 4-to-2 encoding to pick a winner, then holds the grant until the owner releases it.
- Outputs a one-hot grant plus a binary grant index; the index drives downstream mux selects.
- Sits between request sources and a shared datapath/bus.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4; any other value is unsupported.
- IDX_W, 2, width of gnt_idx; equals log2(NUM_REQ).
- MAX_HOLD, 8, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  request vector; bit i = requester i wants the resource.
- done  input  1  single-cycle release pulse from the current owner.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of the owner; valid only while gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst=1) values:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant drops all outputs immediately, without waiting for a clock edge.
- State IDLE:
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, ptr=(winner+1) mod 4, hold_cnt=0.
  - If req=0, remain in IDLE.
  - Latency from req assertion to gnt is 1 cycle.
- State GRANT: release occurs on the edge where any of the following holds:
  - done=1; or
  - req[gnt_idx]=0 (owner withdrew its request); or
  - timeout condition (see Optional Feature).
- On release:
  - Next edge: gnt=0, gnt_valid=0, state=IDLE.
  - gnt_idx keeps its last value.
- Mandatory IDLE cycle:
  - At least one IDLE cycle always separates consecutive grants (bus turnaround).
  - Back-to-back requesters therefore see a grant every 2 cycles at minimum.
- Fairness:
  - The ptr update guarantees a requester that holds req high is granted within 3 other grants.
  - ptr wraps 3 -> 0.
- Other inputs:
  - req changes on non-owners during GRANT are ignored until IDLE.
  - done while in IDLE is ignored.
- Simultaneous events:
  - done and owner deassertion in the same cycle produce a single release.
  - If release and timeout coincide, timeout still pulses.
- hold_cnt:
  - 8-bit counter; increments every GRANT cycle; saturates at 255.
  - Cleared on entry to GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and no other release condition applies, force release on that edge.
  - timeout=1 for exactly the cycle in which gnt returns to 0.
  - A grant therefore lasts at most MAX_HOLD cycles.
- Not defined:
  - No forced release; the grant is held indefinitely until done or owner withdrawal.
  - timeout is tied to 0.
  - hold_cnt logic may be removed.

Test Plan:
- Reset: drive rst=1 with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0. Release rst; first edge -> gnt=4'b0001, gnt_idx=0.
- Round-robin: hold req=4'b1111 and pulse done one cycle after each grant -> grant sequence is idx 0,1,2,3,0 with one IDLE cycle between grants, i.e. a grant every 2 cycles.
- Skip and wrap: with ptr=3 and req=4'b0101 -> gnt=4'b0001 (idx 0), then gnt=4'b0100 (idx 2), ptr=3.
- Owner withdrawal: grant idx 1, then drop req[1] while req[3]=1 -> gnt=0 next edge, IDLE for 1 cycle, then gnt=4'b1000.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=4'b0010, never pulse done -> gnt=4'b0010 for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=4'b0010 again. Without the macro, the grant is held for 100+ cycles and timeout stays 0.
- Async reset mid-grant: assert rst between clock edges while gnt=4'b0100 -> outputs go to 0 immediately. After release, arbitration starts again from ptr=0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with grant hold and a mandatory idle turnaround cycle.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles and pulse timeout.
module rr_arbiter_4 #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               any_req;
  logic               timeout_hit;

  // Rotating-priority scan: the first set request at or after ptr wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_nxt;
  logic       timeout_q, timeout_nxt;

  assign timeout_hit = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1));
  assign timeout     = timeout_q;

  // hold_cnt restarts at zero on every new grant and saturates at 255.
  always_comb begin
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    if (state == IDLE) begin
      hold_nxt = '0;
    end else begin
      timeout_nxt = timeout_hit;
      if (hold_cnt != 8'hFF) hold_nxt = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_nxt;
      timeout_q <= timeout_nxt;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // A released grant always returns to IDLE, giving one turnaround cycle between owners.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          gnt_nxt   = NUM_REQ'(1) << winner;
          idx_nxt   = winner;
          ptr_nxt   = winner + IDX_W'(1);
        end
      end
      GRANT: begin
        if (done || !req[gnt_idx] || timeout_hit) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      ptr     <= ptr_nxt;
    end
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4; timeout checks follow ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive inputs, advance one clock edge and settle just after it.
  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] g, input logic [1:0] idx);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(g));
    checkOutput({tag, "_valid"}, 32'(gnt_valid), 32'(g != 4'b0000));
    if (g != 4'b0000) checkOutput({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
  endtask

  logic [1:0] rr_seq [4];

  initial begin
    rr_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
    checkOutput("rst_idx", 32'(gnt_idx), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    applyStimulus(4'b1111, 1'b0);
    checkGrant("first", 4'b0001, 2'd0);

    // Round robin: release one cycle after each grant, expect idx 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkGrant("rr_idle", 4'b0000, 2'd0);
      applyStimulus(4'b1111, 1'b0);
      checkGrant("rr_grant", 4'b0001 << rr_seq[i], rr_seq[i]);
    end
    applyStimulus(4'b1111, 1'b1);
    checkGrant("rr_end_idle", 4'b0000, 2'd0);

    // Walk ptr to 3 by granting requester 2.
    applyStimulus(4'b0100, 1'b0);
    checkGrant("setup_ptr3", 4'b0100, 2'd2);
    applyStimulus(4'b0101, 1'b1);
    checkGrant("wrap_idle", 4'b0000, 2'd0);
    applyStimulus(4'b0101, 1'b0);
    checkGrant("wrap_to0", 4'b0001, 2'd0);
    applyStimulus(4'b0101, 1'b1);
    checkGrant("skip_idle", 4'b0000, 2'd0);
    applyStimulus(4'b0101, 1'b0);
    checkGrant("skip_to2", 4'b0100, 2'd2);

    // Owner withdrawal: grant idx 1 (ptr=3 scans 3,0,1), then drop req[1].
    applyStimulus(4'b0010, 1'b1);
    checkGrant("wd_setup_idle", 4'b0000, 2'd0);
    applyStimulus(4'b0010, 1'b0);
    checkGrant("wd_grant1", 4'b0010, 2'd1);
    applyStimulus(4'b1000, 1'b0);
    checkGrant("wd_release", 4'b0000, 2'd0);
    checkOutput("wd_idx_kept", 32'(gnt_idx), 32'd1);
    applyStimulus(4'b1000, 1'b0);
    checkGrant("wd_grant3", 4'b1000, 2'd3);

    // done together with withdrawal gives one release; done in IDLE is ignored.
    applyStimulus(4'b0000, 1'b1);
    checkGrant("both_release", 4'b0000, 2'd0);
    applyStimulus(4'b0000, 1'b1);
    checkGrant("idle_done", 4'b0000, 2'd0);
    checkOutput("idle_timeout", 32'(timeout), 32'h0);

    // Grant hold / timeout with ptr=0 and only requester 1 asking.
    applyStimulus(4'b0010, 1'b0);
    checkGrant("hold_start", 4'b0010, 2'd1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0010, 1'b0);
      checkGrant("hold_cycle", 4'b0010, 2'd1);
      checkOutput("hold_no_to", 32'(timeout), 32'h0);
    end
    applyStimulus(4'b0010, 1'b0);
    checkGrant("to_release", 4'b0000, 2'd0);
    checkOutput("to_pulse", 32'(timeout), 32'h1);
    applyStimulus(4'b0010, 1'b0);
    checkGrant("to_regrant", 4'b0010, 2'd1);
    checkOutput("to_cleared", 32'(timeout), 32'h0);
`else
    for (int i = 0; i < 110; i++) begin
      applyStimulus(4'b0010, 1'b0);
      if (i % 10 == 9) begin
        checkGrant("hold_long", 4'b0010, 2'd1);
        checkOutput("hold_no_to", 32'(timeout), 32'h0);
      end
    end
`endif
    applyStimulus(4'b0000, 1'b0);
    checkGrant("hold_release", 4'b0000, 2'd0);

    // ptr is now 2; grant requester 2 then reset between edges.
    applyStimulus(4'b0100, 1'b0);
    checkGrant("ar_grant", 4'b0100, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_gnt", 32'(gnt), 32'h0);
    checkOutput("ar_valid", 32'(gnt_valid), 32'h0);
    checkOutput("ar_timeout", 32'(timeout), 32'h0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkGrant("ar_restart", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
